snake_body_streamer: RTL and testbench



---
 rtl/snake_body_streamer.sv | 165 ++++++++++++++++
 tb/tb_snake_body_streamer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/snake_body_streamer.sv
// rtl/snake_body_streamer.sv - snake position state with per-clock body segment stream
//
// Holds the snake head and body array, applies moves, growth, screen wrap and
// self-collision, and streams one body entry per clock to the renderer.
// State only changes at the end of a sweep, so every sweep shows one snapshot.
//
// Ports:
//   clock_25, reset           pixel clock, synchronous active-high reset
//   move_tick, direction      move request and requested heading (00 up, 01 down, 10 right, 11 left)
//   grow                      lengthen by one on the next committed move
//   snake_head_x/y            committed head coordinates
//   snake_body_x/y            body entry at index body_count
//   body_count                stream index, 0..SNAKE_LENGTH_MAX-2
//   snake_length              valid body entries including the tail
//   current_dir               committed heading
//   sweep_done                high while body_count is the last index
//   self_collision            sticky collision flag
module snake_body_streamer #(
  parameter int SNAKE_LENGTH_BIT = 4,
  parameter int SNAKE_LENGTH_MAX = 16,
  parameter int GRID_W           = 124,
  parameter int GRID_H           = 81,
  parameter int HEAD_X0          = 62,
  parameter int HEAD_Y0          = 40
) (
  input  logic                        clock_25,
  input  logic                        reset,
  input  logic                        move_tick,
  input  logic [1:0]                  direction,
  input  logic                        grow,
  output logic [6:0]                  snake_head_x,
  output logic [6:0]                  snake_head_y,
  output logic [6:0]                  snake_body_x,
  output logic [6:0]                  snake_body_y,
  output logic [SNAKE_LENGTH_BIT-1:0] body_count,
  output logic [SNAKE_LENGTH_BIT-1:0] snake_length,
  output logic [1:0]                  current_dir,
  output logic                        sweep_done,
  output logic                        self_collision
);

  localparam int N = SNAKE_LENGTH_MAX - 1;
  localparam logic [SNAKE_LENGTH_BIT-1:0] LAST_IDX = SNAKE_LENGTH_BIT'(SNAKE_LENGTH_MAX - 2);
  localparam logic [SNAKE_LENGTH_BIT-1:0] LEN_MAX  = SNAKE_LENGTH_BIT'(SNAKE_LENGTH_MAX - 1);
  localparam logic [6:0] X_MAX = 7'(GRID_W - 1);
  localparam logic [6:0] Y_MAX = 7'(GRID_H - 1);

  logic [6:0]                  r_head_x, r_head_y;
  logic [6:0]                  r_body_x [N];
  logic [6:0]                  r_body_y [N];
  logic [SNAKE_LENGTH_BIT-1:0] r_len;
  logic [SNAKE_LENGTH_BIT-1:0] r_count;
  logic [1:0]                  r_dir;
  logic [6:0]                  r_out_x, r_out_y;
  logic                        r_coll;
  logic                        r_move_pending;
  logic                        r_grow_pending;

  logic                        w_last;
  logic                        w_commit;
  logic                        w_reverse;
  logic [1:0]                  w_dir;
  logic [6:0]                  w_next_x, w_next_y;
  logic [SNAKE_LENGTH_BIT-1:0] w_new_len;
  logic [SNAKE_LENGTH_BIT-1:0] w_next_count;
  logic                        w_hit;

  assign w_last       = (r_count == LAST_IDX);
  assign w_commit     = w_last && (r_move_pending || move_tick) && !r_coll;
  assign w_next_count = r_count + 1'b1;

  // Reverse pairs differ only in bit 0 (up/down, right/left).
  assign w_reverse = (direction[1] == r_dir[1]) && (direction[0] != r_dir[0]);
  assign w_dir     = w_reverse ? r_dir : direction;

  assign w_new_len = ((r_grow_pending || grow) && (r_len != LEN_MAX)) ? r_len + 1'b1 : r_len;

  // Next head position with compare-and-load wrap at the grid edges.
  always_comb begin
    w_next_x = r_head_x;
    w_next_y = r_head_y;
    case (w_dir)
      2'b00:   w_next_y = (r_head_y == 7'd0)  ? Y_MAX : r_head_y - 7'd1;
      2'b01:   w_next_y = (r_head_y == Y_MAX) ? 7'd0  : r_head_y + 7'd1;
      2'b10:   w_next_x = (r_head_x == X_MAX) ? 7'd0  : r_head_x + 7'd1;
      default: w_next_x = (r_head_x == 7'd0)  ? X_MAX : r_head_x - 7'd1;
    endcase
  end

  // Compare the new head against the post-shift body: entry 0 becomes the old
  // head, entry i becomes old entry i-1; only entries below the new length count.
  always_comb begin
    w_hit = (w_next_x == r_head_x) && (w_next_y == r_head_y) && (w_new_len != '0);
    for (int i = 1; i < N; i++) begin
      if ((SNAKE_LENGTH_BIT'(i) < w_new_len) &&
          (w_next_x == r_body_x[i-1]) && (w_next_y == r_body_y[i-1])) begin
        w_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_25) begin
    if (reset) begin
      r_head_x       <= 7'(HEAD_X0);
      r_head_y       <= 7'(HEAD_Y0);
      for (int i = 0; i < N; i++) begin
        r_body_x[i] <= 7'(HEAD_X0 - 1 - i);
        r_body_y[i] <= 7'(HEAD_Y0);
      end
      r_len          <= SNAKE_LENGTH_BIT'(2);
      r_dir          <= 2'b10;
      r_count        <= '0;
      r_out_x        <= 7'(HEAD_X0 - 1);
      r_out_y        <= 7'(HEAD_Y0);
      r_coll         <= 1'b0;
      r_move_pending <= 1'b0;
      r_grow_pending <= 1'b0;
    end else begin
      if (w_commit) begin
        r_head_x    <= w_next_x;
        r_head_y    <= w_next_y;
        r_dir       <= w_dir;
        r_len       <= w_new_len;
        r_body_x[0] <= r_head_x;
        r_body_y[0] <= r_head_y;
        for (int i = 1; i < N; i++) begin
          r_body_x[i] <= r_body_x[i-1];
          r_body_y[i] <= r_body_y[i-1];
        end
        if (w_hit) begin
          r_coll <= 1'b1;
        end
        // Requests arriving in the commit cycle are consumed here.
        r_move_pending <= 1'b0;
        r_grow_pending <= 1'b0;
      end else begin
        r_move_pending <= r_move_pending | move_tick;
        r_grow_pending <= r_grow_pending | grow;
      end

      // The stream output is loaded alongside its index; after a commit the
      // new entry 0 is the old head.
      if (w_last) begin
        r_count <= '0;
        r_out_x <= w_commit ? r_head_x : r_body_x[0];
        r_out_y <= w_commit ? r_head_y : r_body_y[0];
      end else begin
        r_count <= w_next_count;
        r_out_x <= r_body_x[w_next_count];
        r_out_y <= r_body_y[w_next_count];
      end
    end
  end

  assign snake_head_x   = r_head_x;
  assign snake_head_y   = r_head_y;
  assign snake_body_x   = r_out_x;
  assign snake_body_y   = r_out_y;
  assign body_count     = r_count;
  assign snake_length   = r_len;
  assign current_dir    = r_dir;
  assign sweep_done     = w_last;
  assign self_collision = r_coll;

endmodule

// File: tb/tb_snake_body_streamer.sv
// tb/tb_snake_body_streamer.sv - scoreboard bench for snake_body_streamer
module tb_snake_body_streamer;

  localparam int LB   = 4;
  localparam int LMAX = 16;
  localparam int NB   = LMAX - 1;
  localparam int GW   = 124;
  localparam int GH   = 81;
  localparam int HX0  = 62;
  localparam int HY0  = 40;

  logic          clock_25 = 1'b0;
  logic          reset;
  logic          move_tick;
  logic [1:0]    direction;
  logic          grow;
  logic [6:0]    snake_head_x, snake_head_y, snake_body_x, snake_body_y;
  logic [LB-1:0] body_count, snake_length;
  logic [1:0]    current_dir;
  logic          sweep_done, self_collision;

  always #20 clock_25 = ~clock_25;

  snake_body_streamer #(
    .SNAKE_LENGTH_BIT(LB), .SNAKE_LENGTH_MAX(LMAX), .GRID_W(GW), .GRID_H(GH),
    .HEAD_X0(HX0), .HEAD_Y0(HY0)
  ) dut (
    .clock_25(clock_25), .reset(reset), .move_tick(move_tick), .direction(direction),
    .grow(grow), .snake_head_x(snake_head_x), .snake_head_y(snake_head_y),
    .snake_body_x(snake_body_x), .snake_body_y(snake_body_y), .body_count(body_count),
    .snake_length(snake_length), .current_dir(current_dir), .sweep_done(sweep_done),
    .self_collision(self_collision)
  );

  typedef struct {
    int cnt; int bx; int by; int hx; int hy; int len; int dir; int sw; int col;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model: the snake as a head plus a list of segments, newest first.
  int m_hx, m_hy, m_len, m_dir, m_idx, m_mp, m_gp, m_col;
  int m_bx[$];
  int m_by[$];
  int m_opp[4] = '{1, 0, 3, 2};
  int m_nd;
  exp_t m_e;

  always @(posedge clock_25) begin
    if (reset) begin
      m_hx = HX0; m_hy = HY0; m_len = 2; m_dir = 2; m_idx = 0;
      m_mp = 0; m_gp = 0; m_col = 0;
      m_bx.delete(); m_by.delete();
      for (int i = 0; i < NB; i++) begin
        m_bx.push_back(HX0 - 1 - i);
        m_by.push_back(HY0);
      end
    end else begin
      if (m_idx == NB - 1 && (m_mp != 0 || move_tick) && m_col == 0) begin
        m_nd = (int'(direction) == m_opp[m_dir]) ? m_dir : int'(direction);
        m_dir = m_nd;
        m_bx.push_front(m_hx); m_by.push_front(m_hy);
        void'(m_bx.pop_back()); void'(m_by.pop_back());
        case (m_dir)
          0: m_hy = (m_hy + GH - 1) % GH;
          1: m_hy = (m_hy + 1) % GH;
          2: m_hx = (m_hx + 1) % GW;
          default: m_hx = (m_hx + GW - 1) % GW;
        endcase
        if ((m_gp != 0 || grow) && m_len < NB) m_len++;
        for (int i = 0; i < m_len; i++)
          if (m_bx[i] == m_hx && m_by[i] == m_hy) m_col = 1;
        m_mp = 0; m_gp = 0;
      end else begin
        if (move_tick) m_mp = 1;
        if (grow) m_gp = 1;
      end
      m_idx = (m_idx + 1) % NB;
    end
    m_e.cnt = m_idx; m_e.bx = m_bx[m_idx]; m_e.by = m_by[m_idx];
    m_e.hx = m_hx; m_e.hy = m_hy; m_e.len = m_len; m_e.dir = m_dir;
    m_e.sw = (m_idx == NB - 1) ? 1 : 0; m_e.col = m_col;
    q.push_back(m_e);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(negedge clock_25) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("body_count", int'(body_count), e.cnt);
      chk("body_x", int'(snake_body_x), e.bx);
      chk("body_y", int'(snake_body_y), e.by);
      chk("head_x", int'(snake_head_x), e.hx);
      chk("head_y", int'(snake_head_y), e.hy);
      chk("length", int'(snake_length), e.len);
      chk("dir", int'(current_dir), e.dir);
      chk("sweep_done", int'(sweep_done), e.sw);
      chk("collision", int'(self_collision), e.col);
    end
  end

  task automatic mv(input int d, input bit g);
    @(posedge clock_25); #1;
    direction = 2'(d); move_tick = 1'b1; grow = g;
    @(posedge clock_25); #1;
    move_tick = 1'b0; grow = 1'b0;
    repeat (NB) @(posedge clock_25);
  endtask

  initial begin
    reset = 1'b1; move_tick = 1'b0; grow = 1'b0; direction = 2'b10;
    repeat (3) @(posedge clock_25);
    #1 reset = 1'b0;
    repeat (32) @(posedge clock_25);

    mv(2, 1'b0);
    for (int k = 0; k < 70; k++) mv(2, k < 16);     // wraps x, saturates length
    for (int k = 0; k < 45; k++) mv((k % 5 == 0) ? 1 : 0, 1'b0); // wraps y, reverse ignored
    mv(2, 1'b0);
    mv(3, 1'b0);                                     // reverse of right: stays right

    // Mid-sweep reset with pending requests, then the collision scenario.
    repeat (5) @(posedge clock_25);
    #1 move_tick = 1'b1; grow = 1'b1;
    @(posedge clock_25); #1 move_tick = 1'b0; grow = 1'b0; reset = 1'b1;
    @(posedge clock_25); #1 reset = 1'b0;
    repeat (NB) @(posedge clock_25);
    mv(2, 1'b1);
    mv(2, 1'b1);
    mv(0, 1'b0);
    mv(3, 1'b0);
    mv(1, 1'b0);
    for (int k = 0; k < 3; k++) mv(k, 1'b1);

    // Randomized play with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clock_25); #1;
      reset     = ($urandom_range(0, 399) == 0);
      move_tick = ($urandom_range(0, 7) == 0);
      grow      = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) direction = 2'($urandom_range(0, 3));
    end
    #1 reset = 1'b0; move_tick = 1'b0; grow = 1'b0;
    repeat (4) @(posedge clock_25);
    @(negedge clock_25); #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
